// File: rtl/stream_arb_mux.sv
// Registered N-to-1 valid/ready stream multiplexer with fixed-priority, round-robin
// or explicit-select arbitration and a single output register stage.
module stream_arb_mux #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int MODE  = 1,
    parameter int SELW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    input  logic [SELW-1:0]    sel,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_src,
    input  logic               out_ready
);

    logic [SELW-1:0]  rr_ptr;
    logic [SELW-1:0]  winner;
    logic             has_winner;
    logic             load_ok;
    logic [WIDTH-1:0] win_data;

    assign load_ok = !out_valid || out_ready;

    // Loops run from the top down so the last hit (the preferred channel) wins.
    always_comb begin
        has_winner = 1'b0;
        winner     = '0;
        if (MODE == 0) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    has_winner = 1'b1;
                    winner     = SELW'(i);
                end
            end
        end else if (MODE == 1) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (in_valid[(int'(rr_ptr) + k) % N]) begin
                    has_winner = 1'b1;
                    winner     = SELW'((int'(rr_ptr) + k) % N);
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (sel == SELW'(i) && in_valid[i]) begin
                    has_winner = 1'b1;
                    winner     = SELW'(i);
                end
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (winner == SELW'(i)) begin
                win_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = !rst && load_ok && has_winner && (winner == SELW'(i));
        end
    end

    // A stall (load_ok low) leaves every register untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            rr_ptr    <= '0;
        end else if (load_ok) begin
            if (has_winner) begin
                out_valid <= 1'b1;
                out_data  <= win_data;
                out_src   <= winner;
                if (MODE == 1) begin
                    rr_ptr <= (int'(winner) == N - 1) ? '0 : winner + 1'b1;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_arb_mux.sv
// Scoreboard bench for stream_arb_mux: four builds (round-robin, fixed priority,
// explicit select N=4 and N=3) driven by directed vectors.
module tb_stream_arb_mux;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] src;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid  [4];
    logic [31:0] in_data   [4];
    logic [1:0]  sel       [4];
    logic        out_ready [4];
    logic [3:0]  in_ready  [4];
    logic        out_valid [4];
    logic [7:0]  out_data  [4];
    logic [1:0]  out_src   [4];
    logic [2:0]  rdy3;

    exp_t exp_q [4][$];
    int   compared   = 0;
    int   mismatched = 0;

    logic [1:0] bp_sel   [5] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1};
    logic [3:0] bp_valid [5] = '{4'b1111, 4'b0011, 4'b1010, 4'b0101, 4'b1111};

    always #5 clk = ~clk;

    stream_arb_mux #(.WIDTH(8), .N(4), .MODE(1)) u_rr (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_data(in_data[0]),
        .in_ready(in_ready[0]), .sel(sel[0]), .out_valid(out_valid[0]),
        .out_data(out_data[0]), .out_src(out_src[0]), .out_ready(out_ready[0])
    );

    stream_arb_mux #(.WIDTH(8), .N(4), .MODE(0)) u_fp (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_data(in_data[1]),
        .in_ready(in_ready[1]), .sel(sel[1]), .out_valid(out_valid[1]),
        .out_data(out_data[1]), .out_src(out_src[1]), .out_ready(out_ready[1])
    );

    stream_arb_mux #(.WIDTH(8), .N(4), .MODE(2)) u_sel4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_data(in_data[2]),
        .in_ready(in_ready[2]), .sel(sel[2]), .out_valid(out_valid[2]),
        .out_data(out_data[2]), .out_src(out_src[2]), .out_ready(out_ready[2])
    );

    stream_arb_mux #(.WIDTH(8), .N(3), .MODE(2)) u_sel3 (
        .clk(clk), .rst(rst), .in_valid(in_valid[3][2:0]), .in_data(in_data[3][23:0]),
        .in_ready(rdy3), .sel(sel[3]), .out_valid(out_valid[3]),
        .out_data(out_data[3]), .out_src(out_src[3]), .out_ready(out_ready[3])
    );

    assign in_ready[3] = {1'b0, rdy3};

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int k, input logic [3:0] valid,
                                 input logic [31:0] data, input logic [1:0] s,
                                 input logic ready);
        in_valid[k]  = valid;
        in_data[k]   = data;
        sel[k]       = s;
        out_ready[k] = ready;
    endtask

    task automatic pushExp(input int k, input logic [7:0] data, input logic [1:0] src);
        exp_t e;
        e.data = data;
        e.src  = src;
        exp_q[k].push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every word the DUT hands downstream must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL mon%0d: got unexpected word src=%0d data=%h, required none",
                                 k, out_src[k], out_data[k]);
                    end else begin
                        e = exp_q[k].pop_front();
                        checkOutput($sformatf("mon%0d", k), {22'd0, out_src[k], out_data[k]},
                                    {22'd0, e.src, e.data});
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 4; k++) applyStimulus(k, 4'b0000, 32'd0, 2'd0, 1'b0);
        applyStimulus(0, 4'b1111, 32'hA3A2A1A0, 2'd0, 1'b1);

        repeat (2) begin
            tick();
            @(negedge clk);
            checkOutput("rst_in_ready", 32'(in_ready[0]), 32'h0);
            checkOutput("rst_out_valid", 32'(out_valid[0]), 32'h0);
            checkOutput("rst_out_data", 32'(out_data[0]), 32'h0);
            checkOutput("rst_out_src", 32'(out_src[0]), 32'h0);
        end

        // Round-robin: six grants 0,1,2,3,0,1; the sixth is checked directly
        // because reset is pulsed while it sits in the output register.
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) pushExp(0, 8'hA0 + 8'(i % 4), 2'(i % 4));
        @(negedge clk);
        checkOutput("rr_first_ready", 32'(in_ready[0]), 32'h1);
        repeat (5) tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rr_sixth_data", 32'(out_data[0]), 32'hA1);
        checkOutput("rr_sixth_src", 32'(out_src[0]), 32'h1);
        checkOutput("rr_sixth_valid", 32'(out_valid[0]), 32'h1);
        checkOutput("midrst_in_ready", 32'(in_ready[0]), 32'h0);
        tick();
        rst = 1'b0;
        pushExp(0, 8'hA0, 2'd0);
        @(negedge clk);
        checkOutput("midrst_out_valid", 32'(out_valid[0]), 32'h0);
        checkOutput("midrst_grant", 32'(in_ready[0]), 32'h1);
        tick();
        in_valid[0] = 4'b0000;
        tick();
        @(negedge clk);
        checkOutput("rr_idle_valid", 32'(out_valid[0]), 32'h0);

        // Fixed priority
        tick();
        applyStimulus(1, 4'b1010, 32'h33221100, 2'd0, 1'b1);
        repeat (3) pushExp(1, 8'h11, 2'd1);
        @(negedge clk);
        checkOutput("fp_ready_1010", 32'(in_ready[1]), 32'h2);
        tick();
        tick();
        tick();
        in_valid[1] = 4'b1000;
        pushExp(1, 8'h33, 2'd3);
        @(negedge clk);
        checkOutput("fp_ready_1000", 32'(in_ready[1]), 32'h8);
        tick();
        in_valid[1] = 4'b0000;
        tick();

        // Explicit select and backpressure
        tick();
        applyStimulus(2, 4'b1111, 32'hD355D1D0, 2'd2, 1'b1);
        pushExp(2, 8'h55, 2'd2);
        @(negedge clk);
        checkOutput("sel2_ready", 32'(in_ready[2]), 32'h4);
        tick();
        out_ready[2] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            sel[2]      = bp_sel[i];
            in_valid[2] = bp_valid[i];
            @(negedge clk);
            checkOutput($sformatf("bp_data%0d", i), 32'(out_data[2]), 32'h55);
            checkOutput($sformatf("bp_valid%0d", i), 32'(out_valid[2]), 32'h1);
            checkOutput($sformatf("bp_ready%0d", i), 32'(in_ready[2]), 32'h0);
        end
        tick();
        applyStimulus(2, 4'b1111, 32'hD355D1D0, 2'd1, 1'b1);
        pushExp(2, 8'hD1, 2'd1);
        @(negedge clk);
        checkOutput("bp_release_ready", 32'(in_ready[2]), 32'h2);
        tick();
        in_valid[2] = 4'b0000;
        tick();
        @(negedge clk);
        checkOutput("bp_idle_valid", 32'(out_valid[2]), 32'h0);

        // Out-of-range select on the N=3 build
        tick();
        applyStimulus(3, 4'b0111, 32'h00C2C1C0, 2'd0, 1'b1);
        pushExp(3, 8'hC0, 2'd0);
        @(negedge clk);
        checkOutput("oor_sel0_ready", 32'(in_ready[3]), 32'h1);
        tick();
        sel[3] = 2'd3;
        @(negedge clk);
        checkOutput("oor_ready", 32'(in_ready[3]), 32'h0);
        checkOutput("oor_valid_before", 32'(out_valid[3]), 32'h1);
        tick();
        @(negedge clk);
        checkOutput("oor_valid_after", 32'(out_valid[3]), 32'h0);
        checkOutput("oor_data_hold", 32'(out_data[3]), 32'hC0);
        checkOutput("oor_src_hold", 32'(out_src[3]), 32'h0);

        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("drain%0d", k), 32'(exp_q[k].size()), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
